alu_accum_stage: RTL and testbench

//  Result stage directly downstream of the ALU adder/subtractor. Consumes per-cycle sums

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_sat_add.sv | 50 +++++
 rtl/alu_accum_stage.sv | 184 ++++++++++++++++++
 tb/tb_alu_accum_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result/accumulate stage.
//   LEN_DEF / CNT_W_DEF : default data and beat-count widths
//   state_e             : accumulate FSM states (IDLE = no partial group,
//                         ACCUM = partial group in progress)
//   smax_f / smin_f     : two's complement extreme values for a given width,
//                         returned as bit patterns in a 32-bit container
//                         (truncate to the data width at the use site)
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int LEN_DEF   = 9;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Largest positive value representable in len bits: 0111...1
    function automatic logic [31:0] smax_f(input int unsigned len);
        smax_f = (32'd1 << (len - 32'd1)) - 32'd1;
    endfunction

    // Most negative value representable in len bits: 1000...0
    function automatic logic [31:0] smin_f(input int unsigned len);
        smin_f = 32'd1 << (len - 32'd1);
    endfunction

endpackage

// File: rtl/alu_sat_add.sv
// ----------------------------------------------------------------------------
// alu_sat_add
// Combinational signed LEN-bit adder with overflow detection.
// Optional feature macro: ALU_ACC_SAT_EN -- when defined, an overflowing sum
// is clamped to SMAX/SMIN (direction taken from the extended sign bit);
// otherwise the sum wraps modulo 2^LEN.
// Ports:
//   a_i    in  LEN  signed operand
//   b_i    in  LEN  signed operand
//   sum_o  out LEN  (possibly clamped) sum
//   ovf_o  out 1    signed overflow of the unclamped addition
// ----------------------------------------------------------------------------
module alu_sat_add
    import alu_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic [LEN-1:0] a_i,
    input  logic [LEN-1:0] b_i,
    output logic [LEN-1:0] sum_o,
    output logic           ovf_o
);

`ifdef ALU_ACC_SAT_EN
    localparam logic [LEN-1:0] SMAX_C = LEN'(smax_f(LEN));
    localparam logic [LEN-1:0] SMIN_C = LEN'(smin_f(LEN));
`endif

    logic [LEN:0] sum_ext_s;

    // Sign-extended add; the two top bits disagree exactly on signed overflow
    always_comb begin
        sum_ext_s = {a_i[LEN-1], a_i} + {b_i[LEN-1], b_i};
        ovf_o     = sum_ext_s[LEN] ^ sum_ext_s[LEN-1];
    end

    // Result select: wrap, or clamp toward the true sign held in sum_ext_s[LEN]
    always_comb begin
`ifdef ALU_ACC_SAT_EN
        if (ovf_o) begin
            sum_o = sum_ext_s[LEN] ? SMIN_C : SMAX_C;
        end else begin
            sum_o = sum_ext_s[LEN-1:0];
        end
`else
        sum_o = sum_ext_s[LEN-1:0];
`endif
    end

endmodule

// File: rtl/alu_accum_stage.sv
// ----------------------------------------------------------------------------
// alu_accum_stage
// Result stage after the ALU adder/subtractor. Accumulates a group of beats
// (closed by in_last) into one signed value and hands the group result,
// a sticky overflow flag and a saturating beat count downstream over a
// valid/ready handshake. Result appears one cycle after the last beat.
// Optional feature macro: ALU_ACC_SAT_EN -- saturating arithmetic (overflowed
// input beats and accumulate overflow clamp to SMAX/SMIN); default wraps.
// Ports:
//   clk        in   1      clock, rising edge
//   rstn       in   1      asynchronous active-low reset
//   in_valid   in   1      upstream beat valid
//   in_ready   out  1      stage can accept a beat
//   in_data    in   LEN    ALU sum
//   in_ovf     in   1      ALU signed overflow for in_data
//   in_last    in   1      beat closes the current group
//   flush      in   1      synchronous discard of the partial group
//   out_valid  out  1      group result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  LEN    accumulated group result
//   out_ovf    out  1      sticky overflow over the group
//   out_count  out  CNT_W  beats in group (saturating)
// ----------------------------------------------------------------------------
module alu_accum_stage
    import alu_pkg::*;
#(
    parameter int LEN   = LEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_data,
    input  logic             in_ovf,
    input  logic             in_last,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

`ifdef ALU_ACC_SAT_EN
    localparam logic [LEN-1:0] SMAX_C = LEN'(smax_f(LEN));
    localparam logic [LEN-1:0] SMIN_C = LEN'(smin_f(LEN));
`endif
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [LEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [LEN-1:0]   out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             accept_s;
    logic [LEN-1:0]   fix_s;
    logic [LEN-1:0]   add_a_s;
    logic [LEN-1:0]   sum_s;
    logic             add_ovf_s;
    logic [CNT_W-1:0] cnt_new_s;
    logic             sticky_new_s;

    // Handshake: flush blocks acceptance so a same-cycle beat is dropped
    always_comb begin
        in_ready = (~out_valid_q | out_ready) & ~flush;
        accept_s = in_valid & in_ready;
    end

    // Input fix-up: an overflowed ALU sum has the opposite true sign
    always_comb begin
`ifdef ALU_ACC_SAT_EN
        if (in_ovf) begin
            fix_s = in_data[LEN-1] ? SMAX_C : SMIN_C;
        end else begin
            fix_s = in_data;
        end
`else
        fix_s = in_data;
`endif
    end

    // First beat of a group adds to zero, so the single adder serves both states
    always_comb begin
        if (state_q == ST_ACCUM) begin
            add_a_s      = acc_q;
            sticky_new_s = sticky_q | in_ovf | add_ovf_s;
            cnt_new_s    = (cnt_q == CNT_MAX_C) ? cnt_q : cnt_q + CNT_ONE_C;
        end else begin
            add_a_s      = {LEN{1'b0}};
            sticky_new_s = in_ovf | add_ovf_s;
            cnt_new_s    = CNT_ONE_C;
        end
    end

    alu_sat_add #(
        .LEN (LEN)
    ) u_sat_add (
        .a_i   (add_a_s),
        .b_i   (fix_s),
        .sum_o (sum_s),
        .ovf_o (add_ovf_s)
    );

    // Group accumulation next state
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (flush) begin
            state_d  = ST_IDLE;
            acc_d    = {LEN{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            sticky_d = 1'b0;
        end else if (accept_s) begin
            if (in_last) begin
                state_d  = ST_IDLE;
                acc_d    = {LEN{1'b0}};
                cnt_d    = {CNT_W{1'b0}};
                sticky_d = 1'b0;
            end else begin
                state_d  = ST_ACCUM;
                acc_d    = sum_s;
                cnt_d    = cnt_new_s;
                sticky_d = sticky_new_s;
            end
        end else begin
            state_d  = state_q;
        end
    end

    // Output register: load on a closing beat (even while draining), else drain
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        if (accept_s && in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_s;
            out_ovf_d   = sticky_new_s;
            out_count_d = cnt_new_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            acc_q       <= {LEN{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {LEN{1'b0}};
            out_ovf_q   <= 1'b0;
            out_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_alu_accum_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_accum_stage
// Directed self-checking bench for alu_accum_stage (LEN=9, CNT_W=8).
// A behavioural model turns each driven beat into an expected group result
// pushed onto a scoreboard queue; results are popped when the DUT presents
// them. Honours ALU_ACC_SAT_EN in the model.
// ----------------------------------------------------------------------------
module tb_alu_accum_stage;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       in_ovf;
    logic       in_last;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic       out_ovf;
    logic [7:0] out_count;

    typedef struct {
        logic [8:0] data;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    int   m_acc  = 0;
    int   m_cnt  = 0;
    logic m_ovf  = 1'b0;
    bit   m_busy = 1'b0;

    always #5 clk = ~clk;

    alu_accum_stage #(.LEN(9), .CNT_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model for one accepted beat
    task automatic model_beat(input logic [8:0] d, input logic o, input logic l);
        int   v;
        int   s;
        logic aovf;
        exp_t e;
        if (!m_busy) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        v = int'($signed(d));
`ifdef ALU_ACC_SAT_EN
        if (o) v = d[8] ? 255 : -256;
`endif
        s    = m_busy ? m_acc + v : v;
        aovf = (s > 255) || (s < -256);
        if (aovf) begin
`ifdef ALU_ACC_SAT_EN
            s = (s > 255) ? 255 : -256;
`else
            s = (s > 255) ? s - 512 : s + 512;
`endif
        end
        m_ovf = m_ovf | o | aovf;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (l) begin
            e.data = s[8:0];
            e.ovf  = m_ovf;
            e.cnt  = m_cnt[7:0];
            sb.push_back(e);
            m_busy = 1'b0;
        end else begin
            m_acc  = s;
            m_busy = 1'b1;
        end
    endtask

    // Drive one beat and wait (bounded) until it is accepted
    task automatic send(input logic [8:0] d, input logic o, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        in_last  = l;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        model_beat(d, o, l);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_ovf   = 1'b0;
    endtask

    // Wait (bounded) for a result and compare against the scoreboard head
    task automatic check_out(input string tag);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, {23'd0, out_data}, {23'd0, e.data});
            chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, e.ovf});
            chk({tag, "_count"}, {24'd0, out_count}, {24'd0, e.cnt});
        end
    endtask

    initial begin
        exp_t e;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 9'd0;
        in_ovf    = 1'b0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {23'd0, out_data}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_count", {24'd0, out_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // 1: plain three-beat group
        send(9'd10, 1'b0, 1'b0);
        send(9'd20, 1'b0, 1'b0);
        send(9'h1FB, 1'b0, 1'b1);
        check_out("t1");

        // 2: single overflowed beat
        send(9'h100, 1'b1, 1'b1);
        check_out("t2");

        // 3: positive accumulate overflow
        send(9'd200, 1'b0, 1'b0);
        send(9'd100, 1'b0, 1'b1);
        check_out("t3");

        // 3b: negative accumulate overflow (-200 + -100)
        send(9'h138, 1'b0, 1'b0);
        send(9'h19C, 1'b0, 1'b1);
        check_out("t3b");

        // 4: back-pressure, then drain and reload in the same cycle
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(9'd1, 1'b0, 1'b0);
        send(9'd2, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_stall_data", {23'd0, out_data}, {23'd0, sb[0].data});
            chk("t4_stall_count", {24'd0, out_count}, {24'd0, sb[0].cnt});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 9'd7;
        in_ovf    = 1'b0;
        in_last   = 1'b1;
        #1;
        chk("t4_both_in_ready", {31'd0, in_ready}, 32'd1);
        e = sb.pop_front();
        chk("t4_first_data", {23'd0, out_data}, {23'd0, e.data});
        chk("t4_first_count", {24'd0, out_count}, {24'd0, e.cnt});
        model_beat(9'd7, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("t4b");

        // 5: flush drops a same-cycle beat and the partial group
        send(9'd3, 1'b0, 1'b0);
        send(9'd4, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'd99;
        in_last  = 1'b1;
        flush    = 1'b1;
        #1;
        chk("t5_flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_busy   = 1'b0;
        chk("t5_flush_no_out", {31'd0, out_valid}, 32'd0);
        send(9'd7, 1'b0, 1'b1);
        check_out("t5");

        // 6: asynchronous reset mid-group
        @(posedge clk);
        #1;
        send(9'd1, 1'b0, 1'b0);
        send(9'd2, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data", {23'd0, out_data}, 32'd0);
        chk("t6_rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("t6_rst_count", {24'd0, out_count}, 32'd0);
        m_busy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        send(9'd5, 1'b0, 1'b1);
        check_out("t6");

        // 7: beat count saturates at 255
        for (int i = 0; i < 299; i++) begin
            send(9'd0, 1'b0, 1'b0);
        end
        send(9'd1, 1'b0, 1'b1);
        check_out("t7_sat_count");

        @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
